// File: rtl/encode_scheduler.sv
// Round-robin arbiter sharing one shift_encoding engine between NUM_REQ requesters.
// Optional RUN-state timeout is enabled with the ENC_TIMEOUT_EN macro.
module encode_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [0:NUM_REQ*64-1]   req_data,
    input  logic [0:NUM_REQ*64-1]   req_key,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    resp_valid,
    output logic [IDW-1:0]          resp_id,
    output logic [0:63]             resp_data,
    output logic                    resp_err,
    output logic                    busy,
    output logic [0:63]             enc_data_in,
    output logic [0:63]             enc_key,
    output logic                    enc_set,
    input  logic                    enc_status,
    input  logic [0:63]             enc_data_out
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  r_cur_id;
    logic [0:63]     r_job_data;
    logic [0:63]     r_job_key;
    logic            r_status_q;

    logic [IDW-1:0]  w_grant_id;
    logic            w_grant_valid;
    logic [IDW-1:0]  w_cand;
    logic            w_complete;

`ifdef ENC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   r_timer;
`else
    logic            w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign resp_err = 1'b0;
`endif

    function automatic logic [IDW-1:0] wrapIdx(input int v);
        return IDW'(v % NUM_REQ);
    endfunction

    // Scan downward so the nearest requester after last_grant is the last one written.
    always_comb begin
        w_grant_id    = '0;
        w_grant_valid = 1'b0;
        w_cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = wrapIdx(int'(r_last_grant) + k);
            if (req[w_cand]) begin
                w_grant_id    = w_cand;
                w_grant_valid = 1'b1;
            end
        end
    end

    // enc_set is high during the first RUN cycle; status seen then is a leftover level.
    assign w_complete = enc_status & ~r_status_q & ~enc_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_cur_id     <= '0;
            r_job_data   <= '0;
            r_job_key    <= '0;
            r_status_q   <= 1'b0;
            ack          <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_data    <= '0;
            busy         <= 1'b0;
            enc_data_in  <= '0;
            enc_key      <= '0;
            enc_set      <= 1'b0;
`ifdef ENC_TIMEOUT_EN
            resp_err     <= 1'b0;
            r_timer      <= '0;
`endif
        end else begin
            ack        <= '0;
            resp_valid <= 1'b0;
            enc_set    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_job_data <= req_data[int'(w_grant_id)*64 +: 64];
                        r_job_key  <= req_key[int'(w_grant_id)*64 +: 64];
                        r_cur_id   <= w_grant_id;
                        ack        <= NUM_REQ'(1) << w_grant_id;
                        busy       <= 1'b1;
                        r_state    <= LOAD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    enc_set      <= 1'b1;
                    enc_data_in  <= r_job_data;
                    enc_key      <= r_job_key;
                    r_last_grant <= r_cur_id;
                    r_status_q   <= 1'b0;
`ifdef ENC_TIMEOUT_EN
                    r_timer      <= '0;
`endif
                    r_state      <= RUN;
                end
                RUN: begin
                    r_status_q <= enc_status;
                    if (w_complete) begin
                        resp_data <= enc_data_out;
`ifdef ENC_TIMEOUT_EN
                        resp_err  <= 1'b0;
`endif
                        r_state   <= DONE;
                    end
`ifdef ENC_TIMEOUT_EN
                    else if (r_timer == TW'(TIMEOUT_CYCLES)) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
`endif
                end
                DONE: begin
                    resp_valid <= 1'b1;
                    resp_id    <= r_cur_id;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/encode_scheduler.md
# encode_scheduler

Round-robin scheduler that shares one `shift_encoding` engine between `NUM_REQ` requesters (ballot units) in the EVM datapath. It latches a requester's 64-bit block and key, pulses the engine's `set`, waits for `status` completion, and returns the engine's `data_out` tagged with the requester index. It sits between the vote-capture units and the single encoding engine.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDW`, 2: index width, `$clog2(NUM_REQ)`.
- `TIMEOUT_CYCLES`, 128: RUN-state cycle limit; used only with `ENC_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: per-requester request level; held until the matching `ack` bit.
- `req_data` in [0:NUM_REQ*64-1]: requester i owns bits [i*64 : i*64+63].
- `req_key` in [0:NUM_REQ*64-1]: same packing as `req_data`.
- `ack` out NUM_REQ: one-cycle one-hot pulse; request accepted and data/key latched.
- `resp_valid` out 1: one-cycle pulse; the response is valid.
- `resp_id` out IDW: index of the requester owning the response.
- `resp_data` out [0:63]: encoded block.
- `resp_err` out 1: timeout flag, valid with `resp_valid`.
- `busy` out 1: high in every state except IDLE.
- `enc_data_in` out [0:63]: to engine `data_in`.
- `enc_key` out [0:63]: to engine `key`.
- `enc_set` out 1: to engine `set`.
- `enc_status` in 1: from engine `status`.
- `enc_data_out` in [0:63]: from engine `data_out`.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any `req` is high, grant the first high bit at or after `last_grant+1`, searching modulo NUM_REQ.
  - Latch that requester's data and key into the job registers, record `cur_id`, pulse `ack[cur_id]`, and go to LOAD.
- LOAD:
  - `enc_set`=1 for exactly this one cycle.
  - `enc_data_in`/`enc_key` are driven from the job registers.
  - Update `last_grant`=`cur_id`, clear `status_q`, go to RUN.
- RUN:
  - `enc_set`=0. `enc_data_in`/`enc_key` stay stable.
  - `status_q` registers `enc_status` every cycle.
  - Completion is `enc_status`=1 and `status_q`=0, a rising edge. A `status` level still high from the previous job never completes a job.
  - On completion, latch `enc_data_out` into `resp_data` and go to DONE.
- DONE:
  - `resp_valid`=1 for one cycle, with `resp_id`=`cur_id` and `resp_err` as latched. Then go to IDLE.
- Only one job is in flight at a time. New requests are ignored, not acked, while `busy`=1.
- A requester may drop `req` before `ack`; this is legal and no job is issued.
- A requester holding `req` after its `ack` is treated as a new request at the next IDLE, subject to rotation.
- Reset values:
  - FSM=IDLE, `last_grant`=NUM_REQ-1 (requester 0 has first priority).
  - `ack`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `busy`=0.
  - `enc_set`=0, `enc_data_in`=0, `enc_key`=0, `status_q`=0.
- `rst` asserted in any state, including mid-RUN:
  - Aborts the job with no `resp_valid`, and returns to reset values on the next edge.
  - The engine is left to finish on its own; its later `status` edge is ignored in IDLE.

## Timing
- `req` sampled high in IDLE at edge E:
  - `ack` high and job latched during cycle E..E+1.
  - `enc_set` high during cycle E+1..E+2.
  - RUN starts at E+2.
- Engine edge detected at edge F: `resp_valid` is high during F+1..F+2, and `busy` drops at F+2.
- Minimum back-to-back turnaround: the next `ack` comes one cycle after `resp_valid`, because IDLE lasts one cycle.
- Scheduler overhead per job: 4 cycles plus the engine latency.
- All outputs are registered. There are no combinational paths from `req`/`enc_status` to outputs.

## Configuration
- `ENC_TIMEOUT_EN` defined:
  - A RUN-cycle counter (width `$clog2(TIMEOUT_CYCLES+1)`) clears on entering RUN.
  - When the counter reaches TIMEOUT_CYCLES without completion, go to DONE with `resp_err`=1 and `resp_data`=0.
  - Completion and timeout in the same cycle: completion wins, `resp_err`=0.
- `ENC_TIMEOUT_EN` undefined:
  - No counter; RUN waits indefinitely.
  - `resp_err` is tied to 0.

## Test plan
- Engine model with 64-cycle latency. Single request on `req[0]` with data 64'h8967452301efcdab, key 64'h0102030405060708 -> `ack`=0001 for one cycle, `enc_set` high exactly one cycle with those values, then `resp_valid` pulse with `resp_id`=0 and `resp_data` equal to the engine model output.
- `req`=1111 held continuously -> grant order 0,1,2,3,0; each `resp_id` matches; no `ack` while `busy`.
- Stale status: `enc_status` held high into a new job's LOAD -> no completion until a fall then rise; `resp_data` comes from the new job.
- `rst` pulsed at RUN cycle 20 -> no `resp_valid`; all outputs at reset values next cycle; the next request is granted to requester 0 first.
- With `ENC_TIMEOUT_EN`, TIMEOUT_CYCLES=128, engine never asserts `status` -> `resp_valid` with `resp_err`=1, `resp_data`=0; the following job completes normally.
- `req[2]` pulses low before grant while `req[1]` is high -> only requester 1 is acked; no job is issued for 2.
